// File: rtl/dmem_arbiter.sv
// Two-port (pipeline P / DMA D) arbiter in front of a single-port data memory, with
// D starvation protection, alignment checking and a registered response path.
// Optional grant/stall counters are enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_req,
  input  logic                  p_we,
  input  logic [ADDR_WIDTH-1:0] p_addr,
  input  logic [DATA_WIDTH-1:0] p_wdata,
  input  logic [1:0]            p_wtype,
  output logic                  p_gnt,
  output logic                  p_rvalid,
  output logic [DATA_WIDTH-1:0] p_rdata,
  output logic                  p_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [1:0]            d_wtype,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [1:0]            mem_wtype,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]           perf_p_grants,
  output logic [31:0]           perf_d_grants,
  output logic [31:0]           perf_d_stall,
`endif
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [1:0] WT_WORD = 2'b10;

  typedef enum logic [0:0] {PRI_P = 1'b0, PRI_D = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;

  logic                  any_gnt;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [1:0]            sel_wtype;
  logic                  sel_err;

  function automatic logic misaligned(input logic [1:0] wtype, input logic [1:0] a);
    logic bad;
    case (wtype)
      2'b00:   bad = 1'b0;
      2'b01:   bad = a[0];
      2'b10:   bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // State register, holds priority state and starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PRI_P;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Next-state: D is forced ahead after STARVE_LIMIT consecutive denials
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = '0;
    case (state)
      PRI_P: begin
        if (d_req && !d_gnt) begin
          if (starve_cnt == CNT_LAST) begin
            state_nxt = PRI_D;
          end else begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
          end
        end
      end
      PRI_D: state_nxt = PRI_P;
      default: state_nxt = PRI_P;
    endcase
  end

  // Grant outputs from current priority
  always_comb begin
    p_gnt = 1'b0;
    d_gnt = 1'b0;
    case (state)
      PRI_P: begin
        if (p_req)      p_gnt = 1'b1;
        else if (d_req) d_gnt = 1'b1;
      end
      PRI_D: begin
        if (d_req)      d_gnt = 1'b1;
        else if (p_req) p_gnt = 1'b1;
      end
      default: begin
        p_gnt = 1'b0;
        d_gnt = 1'b0;
      end
    endcase
  end

  assign any_gnt   = p_gnt | d_gnt;
  assign sel_we    = d_gnt ? d_we    : p_we;
  assign sel_addr  = d_gnt ? d_addr  : p_addr;
  assign sel_wdata = d_gnt ? d_wdata : p_wdata;
  assign sel_wtype = d_gnt ? d_wtype : p_wtype;
  assign sel_err   = misaligned(sel_wtype, sel_addr[1:0]);

  // Memory drive; idle or errored accesses park the bus
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wtype = WT_WORD;
    if (any_gnt && !sel_err) begin
      mem_we    = sel_we;
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
      mem_wtype = sel_wtype;
    end
  end

  // One-cycle registered responses; rdata holds between loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_rvalid <= 1'b0;
      p_err    <= 1'b0;
      p_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
    end else begin
      p_rvalid <= p_gnt;
      p_err    <= p_gnt & sel_err;
      d_rvalid <= d_gnt;
      d_err    <= d_gnt & sel_err;
      if (p_gnt) begin
        if (sel_err)    p_rdata <= '0;
        else if (!p_we) p_rdata <= mem_rdata;
      end
      if (d_gnt) begin
        if (sel_err)    d_rdata <= '0;
        else if (!d_we) d_rdata <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_p_grants <= '0;
      perf_d_grants <= '0;
      perf_d_stall  <= '0;
    end else begin
      if (p_gnt && (perf_p_grants != 32'hFFFF_FFFF))
        perf_p_grants <= perf_p_grants + 32'd1;
      if (d_gnt && (perf_d_grants != 32'hFFFF_FFFF))
        perf_d_grants <= perf_d_grants + 32'd1;
      if (d_req && !d_gnt && (perf_d_stall != 32'hFFFF_FFFF))
        perf_d_stall <= perf_d_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-lane memory model on the mem_* bus.
// Perf counters are checked when DMEM_ARB_PERF_EN is defined.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_req, p_we, d_req, d_we;
  logic [31:0] p_addr, p_wdata, d_addr, d_wdata;
  logic [1:0]  p_wtype, d_wtype;
  logic        p_gnt, p_rvalid, p_err, d_gnt, d_rvalid, d_err;
  logic [31:0] p_rdata, d_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_wtype;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_p_grants, perf_d_grants, perf_d_stall;
`endif

  logic [31:0] mem [0:63];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_wtype(p_wtype),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata), .p_err(p_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wtype(d_wtype),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wtype(mem_wtype),
`ifdef DMEM_ARB_PERF_EN
    .perf_p_grants(perf_p_grants), .perf_d_grants(perf_d_grants), .perf_d_stall(perf_d_stall),
`endif
    .mem_rdata(mem_rdata)
  );

  // Memory model: combinational read, byte/half/word write, reloaded during reset
  assign mem_rdata = mem_we ? 32'h0 : mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h1122_3344;
    end else if (mem_we) begin
      case (mem_wtype)
        2'b00:   mem[mem_addr[7:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
        2'b01:   mem[mem_addr[7:2]][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
        default: mem[mem_addr[7:2]] <= mem_wdata;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_p(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] wtype);
    p_req = req; p_we = we; p_addr = addr; p_wdata = wdata; p_wtype = wtype;
  endtask

  task automatic drive_d(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] wtype);
    d_req = req; d_we = we; d_addr = addr; d_wdata = wdata; d_wtype = wtype;
  endtask

  task automatic idle();
    drive_p(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
    drive_d(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    #1;
    check("rst_p_rvalid", 32'(p_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rst_p_rdata", p_rdata, 32'h0);
    check("rst_d_err", 32'(d_err), 32'd0);
    check("rst_mem_wtype", 32'(mem_wtype), 32'd2);
    check("rst_p_gnt", 32'(p_gnt), 32'd0);
    tick();

    // Single P load
    drive_p(1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
    #1;
    check("t1_p_gnt", 32'(p_gnt), 32'd1);
    check("t1_d_gnt", 32'(d_gnt), 32'd0);
    check("t1_mem_addr", mem_addr, 32'h10);
    check("t1_mem_we", 32'(mem_we), 32'd0);
    tick();
    idle();
    check("t1_p_rvalid", 32'(p_rvalid), 32'd1);
    check("t1_p_rdata", p_rdata, 32'h1122_3344);
    check("t1_p_err", 32'(p_err), 32'd0);
    tick();
    check("t1_p_rvalid_pulse", 32'(p_rvalid), 32'd0);
    check("t1_p_rdata_hold", p_rdata, 32'h1122_3344);

    // Contention: P x4, D, P x4, D
    drive_p(1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
    drive_d(1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("t2_p_gnt[%0d]", i), 32'(p_gnt), (i == 4 || i == 9) ? 32'd0 : 32'd1);
      check($sformatf("t2_d_gnt[%0d]", i), 32'(d_gnt), (i == 4 || i == 9) ? 32'd1 : 32'd0);
      tick();
      check($sformatf("t2_d_rvalid[%0d]", i), 32'(d_rvalid), (i == 4 || i == 9) ? 32'd1 : 32'd0);
      check($sformatf("t2_p_rvalid[%0d]", i), 32'(p_rvalid), (i == 4 || i == 9) ? 32'd0 : 32'd1);
      if (i == 4) check("t2_d_rdata", d_rdata, 32'h1122_3344);
    end
`ifdef DMEM_ARB_PERF_EN
    check("t2_perf_d_stall", perf_d_stall, 32'd8);
    check("t2_perf_d_grants", perf_d_grants, 32'd2);
    check("t2_perf_p_grants", perf_p_grants, 32'd9);
`endif
    idle();
    tick();

    // Misaligned D word store
    drive_d(1'b1, 1'b1, 32'h6, 32'hDEAD_BEEF, 2'b10);
    #1;
    check("t3_d_gnt", 32'(d_gnt), 32'd1);
    check("t3_mem_we", 32'(mem_we), 32'd0);
    check("t3_mem_addr", mem_addr, 32'h0);
    check("t3_mem_wdata", mem_wdata, 32'h0);
    tick();
    idle();
    check("t3_d_rvalid", 32'(d_rvalid), 32'd1);
    check("t3_d_err", 32'(d_err), 32'd1);
    check("t3_d_rdata", d_rdata, 32'h0);
    check("t3_mem_unchanged", mem[1], 32'h0);
    tick();

    // Byte store then word load
    drive_p(1'b1, 1'b1, 32'h21, 32'hAB, 2'b00);
    #1;
    check("t4_mem_we", 32'(mem_we), 32'd1);
    check("t4_mem_wtype", 32'(mem_wtype), 32'd0);
    check("t4_mem_addr", mem_addr, 32'h21);
    check("t4_mem_wdata", mem_wdata, 32'hAB);
    tick();
    idle();
    check("t4_st_rvalid", 32'(p_rvalid), 32'd1);
    check("t4_st_err", 32'(p_err), 32'd0);
    check("t4_st_rdata_hold", p_rdata, 32'h1122_3344);
    drive_p(1'b1, 1'b0, 32'h20, 32'h0, 2'b10);
    tick();
    idle();
    check("t4_ld_rdata", p_rdata, 32'h0000_AB00);
    check("t4_ld_rvalid", 32'(p_rvalid), 32'd1);

    // Half load at odd address, reserved type, then legal half
    drive_p(1'b1, 1'b0, 32'h23, 32'h0, 2'b01);
    #1;
    check("t4_half_mis_gnt", 32'(p_gnt), 32'd1);
    check("t4_half_mis_mem_addr", mem_addr, 32'h0);
    tick();
    check("t4_half_mis_err", 32'(p_err), 32'd1);
    check("t4_half_mis_rdata", p_rdata, 32'h0);
    drive_p(1'b1, 1'b0, 32'h20, 32'h0, 2'b11);
    tick();
    check("t4_rsvd_err", 32'(p_err), 32'd1);
    drive_p(1'b1, 1'b0, 32'h22, 32'h0, 2'b01);
    tick();
    idle();
    check("t4_half_ok_err", 32'(p_err), 32'd0);
    check("t4_half_ok_rdata", p_rdata, 32'h0000_AB00);

    // D alone is granted in PRI_P
    drive_d(1'b1, 1'b0, 32'h20, 32'h0, 2'b10);
    #1;
    check("t4_d_alone_gnt", 32'(d_gnt), 32'd1);
    tick();
    idle();
    check("t4_d_alone_rdata", d_rdata, 32'h0000_AB00);
    tick();

    // Reset mid-operation after partial starvation count
    drive_p(1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
    drive_d(1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
    tick();
    tick();
    #1;
    check("t5_pre_rst_p_gnt", 32'(p_gnt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_p_rvalid", 32'(p_rvalid), 32'd0);
    check("t5_d_rvalid", 32'(d_rvalid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t5_d_gnt[%0d]", i), 32'(d_gnt), (i == 4) ? 32'd1 : 32'd0);
      tick();
    end
    idle();
    tick();

    // D withdrawn under contention clears the starvation count
    drive_p(1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
    drive_d(1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("t6_d_gnt[%0d]", i), 32'(d_gnt), 32'd0);
      tick();
    end
    d_req = 1'b0;
    #1;
    check("t6_d_gnt_drop", 32'(d_gnt), 32'd0);
    tick();
    check("t6_d_rvalid_drop", 32'(d_rvalid), 32'd0);
    d_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t6_d_gnt_re[%0d]", i), 32'(d_gnt), (i == 4) ? 32'd1 : 32'd0);
      tick();
    end
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
